// File: rtl/fsm_pattern_serializer_if.sv
// fsm_pattern_serializer_if: start handshake, pattern, serial x/y/z and response bundle
interface fsm_pattern_serializer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] pat_x;
    logic [WIDTH-1:0] pat_y;
    logic             z_in;
    logic             ready;
    logic             x;
    logic             y;
    logic             bit_valid;
    logic [WIDTH-1:0] z_word;
    logic             done;
    modport master (
        output start, pat_x, pat_y, z_in,
        input  ready, x, y, bit_valid, z_word, done
    );
    modport slave (
        input  start, pat_x, pat_y, z_in,
        output ready, x, y, bit_valid, z_word, done
    );
endinterface

// File: rtl/fsm_pattern_serializer.sv
// fsm_pattern_serializer: shifts two patterns out on x/y and captures z into a response word
module fsm_pattern_serializer #(
    parameter int WIDTH      = 16,
    parameter int MSB_FIRST  = 1,
    parameter int BIT_CYCLES = 1
) (
    input logic                    clk,
    input logic                    rst,
    fsm_pattern_serializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int IW = $clog2(WIDTH);
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int K0 = MSB_FIRST != 0 ? WIDTH - 1 : 0;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] px_q, px_d, py_q, py_d, z_q, z_d;
    logic [IW-1:0]    idx_q, idx_d, idx_inc, k_cur, k_nxt;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             x_q, x_d, y_q, y_d;
    // idx counts bits already sent; k maps it to the pattern position on the wire
    assign idx_inc = idx_q + IW'(1);
    assign k_cur   = MSB_FIRST != 0 ? IW'(WIDTH - 1) - idx_q : idx_q;
    assign k_nxt   = MSB_FIRST != 0 ? IW'(WIDTH - 1) - idx_inc : idx_inc;
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        z_d     = z_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        x_d     = 1'b0;
        y_d     = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = SHIFT;
                px_d    = bus.pat_x;
                py_d    = bus.pat_y;
                z_d     = '0;
                idx_d   = '0;
                cyc_d   = '0;
                x_d     = bus.pat_x[K0];
                y_d     = bus.pat_y[K0];
            end
            SHIFT: begin
                x_d = x_q;
                y_d = y_q;
                if (cyc_q == CW'(BIT_CYCLES - 1)) begin
                    z_d[k_cur] = bus.z_in;
                    cyc_d      = '0;
                    if (idx_q == IW'(WIDTH - 1)) begin
                        state_d = DONE;
                        x_d     = 1'b0;
                        y_d     = 1'b0;
                    end else begin
                        idx_d = idx_inc;
                        x_d   = px_q[k_nxt];
                        y_d   = py_q[k_nxt];
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            z_q     <= '0;
            idx_q   <= '0;
            cyc_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            z_q     <= z_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end
    assign bus.ready     = state_q == IDLE;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.bit_valid = state_q == SHIFT;
    assign bus.done      = state_q == DONE;
    assign bus.z_word    = z_q;
endmodule

// File: doc/fsm_pattern_serializer.md
Name: fsm_pattern_serializer

Overview:
- Parallel-to-serial stimulus driver for the two-input serial FSM blocks (inputs x, y; output z).
- Accepts two WIDTH-bit patterns on a start handshake and shifts them out one bit per bit-period on x and y.
- Samples the FSM's z output once per bit and assembles it into a WIDTH-bit response word.
- Sits in front of the sequence-detector FSMs; replaces hand-coded bit loops for serial stimulus and response capture.

Parameters:
- WIDTH, 16, number of bits per pattern (legal range 2..32).
- MSB_FIRST, 1, 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first.
- BIT_CYCLES, 1, clock cycles each bit is held on x/y (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to send; accepted only when ready=1.
- pat_x  input  WIDTH  pattern for x; sampled on the accepting edge.
- pat_y  input  WIDTH  pattern for y; sampled on the accepting edge.
- z_in  input  1  serial response from the FSM under drive.
- ready  output  1  block is idle and can accept start.
- x  output  1  serial bit of pat_x (registered).
- y  output  1  serial bit of pat_y (registered).
- bit_valid  output  1  high while x/y carry pattern bits.
- z_word  output  WIDTH  captured response word.
- done  output  1  single-cycle pulse when the transfer completes.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Next cycle: ready=1, x=0, y=0, bit_valid=0, done=0, z_word=0, state IDLE.
  - Reset has priority over every other input, including mid-transfer; a transfer in progress is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, x=y=0, bit_valid=0.
  - start=1 at an edge: latch pat_x/pat_y into shift registers, clear z_word, load the first bit onto x/y, set bit_valid=1, move to SHIFT.
  - Latency: the first bit appears on x/y in the cycle immediately after the accepting edge.
- SHIFT:
  - ready=0.
  - Each bit is held for exactly BIT_CYCLES cycles, counted by a cycle counter.
  - On the last cycle of each bit-period, z_in is sampled into z_word[k], where k is the pattern index of the bit currently on x/y. z_word therefore has the same bit order as pat_x regardless of MSB_FIRST.
  - After the final bit's last cycle, move to DONE.
  - Total time in SHIFT is WIDTH*BIT_CYCLES cycles.
- DONE (one cycle): done=1, bit_valid=0, x=y=0, ready=0; then return to IDLE.
- start while ready=0 (SHIFT or DONE) is ignored and not queued.
- Changes to pat_x/pat_y after acceptance have no effect on the transfer in progress.
- z_word holds its value from DONE until the next accepted start or reset.
- Timing example, WIDTH=16, BIT_CYCLES=1, MSB_FIRST=1, start accepted at edge 0:
  - bit15 on x/y in cycle 1 ... bit0 in cycle 16.
  - done=1 in cycle 17.
  - ready=1 in cycle 18.
- Back-to-back transfers: start held high continuously gives one transfer every WIDTH*BIT_CYCLES+2 cycles.
- Counters are sized with $clog2; the bit index never wraps past WIDTH-1 or below 0.

Test Plan:
1. Reset then start with pat_x=16'h3BC7, pat_y=16'h3BF8, z_in tied to x, BIT_CYCLES=1 -> x sequence 0,0,1,1,1,0,1,1,1,1,0,0,0,1,1,1 in cycles 1..16; y sequence 0,0,1,1,1,0,1,1,1,1,1,1,1,0,0,0; done=1 in cycle 17 only; z_word=16'h3BC7.
2. Same patterns, z_in = x & y -> z_word=16'h3BC0; bit_valid high for exactly 16 cycles.
3. MSB_FIRST=0, pat_x=16'h0001, z_in tied to x -> x=1 in cycle 1 only, then 0; z_word=16'h0001.
4. BIT_CYCLES=3, pat_x=16'hA000 -> x=1 in cycles 1-3, 0 in cycles 4-6, 1 in cycles 7-9; done in cycle 49.
5. start pulsed again in cycle 5 and in the DONE cycle -> ignored; exactly one done pulse; ready=1 in cycle 18.
6. rst asserted in cycle 8 of a transfer -> next cycle x=y=0, bit_valid=0, z_word=0, ready=1, and no done pulse; a new start then completes normally.
